debug_ocimem_arbiter: RTL and testbench

DEBUG_OCIMEM_ARBITER -- requirements
Module: debug_ocimem_arbiter

---
 rtl/debug_ocimem_arbiter.sv | 126 ++++++++++++
 tb/tb_debug_ocimem_arbiter.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_ocimem_arbiter.sv
// Debug-RAM arbiter between a JTAG monitor port and an Avalon-style CPU port.
// A JTAG request is posted, then granted and arbitrated round-robin against the CPU.
module debug_ocimem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jtag_req,
  input  logic              jtag_wr,
  input  logic [DATA_W-1:0] jtag_wdata,
  input  logic              jtag_addr_load,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic              jtag_ovr_clr,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_waitrequest,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] mon_dreg,
  output logic              monitor_ready,
  output logic              jtag_overrun
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] J_WR  = 3'd1;
  localparam logic [2:0] J_RD  = 3'd2;
  localparam logic [2:0] J_RDW = 3'd3;
  localparam logic [2:0] C_WR  = 3'd4;
  localparam logic [2:0] C_RD  = 3'd5;
  localparam logic [2:0] C_RDW = 3'd6;

  logic [2:0]        state_q, state_d;
  logic              pend_q;
  logic              jwr_q;
  logic [DATA_W-1:0] jwd_q;
  logic [ADDR_W-1:0] jaddr_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              last_j_q;
  logic [DATA_W-1:0] mon_q;
  logic [DATA_W-1:0] crd_q;
  logic              rdy_q;
  logic              ovr_q;

  logic is_idle, j_st, acc, drop, jg, cg, done;

  assign is_idle = (state_q == IDLE);
  assign j_st    = (state_q == J_WR) || (state_q == J_RD)
                || (state_q == J_RDW);
  assign acc     = jtag_req & ~pend_q;
  assign drop    = jtag_req & pend_q;
  // last_j_q=0 means CPU was last granted, so JTAG wins a tie
  assign jg      = is_idle & pend_q & (~cpu_req | ~last_j_q);
  assign cg      = is_idle & cpu_req & ~jg;
  assign done    = (state_q == J_WR) || (state_q == J_RDW);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (jg)      state_d = jwr_q ? J_WR : J_RD;
        else if (cg) state_d = cpu_wr ? C_WR : C_RD;
      end
      J_RD:    state_d = J_RDW;
      C_RD:    state_d = C_RDW;
      default: state_d = IDLE;
    endcase
  end

  assign ram_addr  = j_st ? jaddr_q : cpu_addr;
  assign ram_wdata = (state_q == J_WR) ? jwd_q : cpu_wdata;
  assign ram_we    = ~reset
                   & ((state_q == J_WR) || (state_q == C_WR));
  assign cpu_waitrequest = ~reset & cpu_req
                   & ~((state_q == C_WR) || (state_q == C_RDW));
  assign cpu_readdata = reset ? '0
                      : (state_q == C_RDW) ? ram_rdata : crd_q;
  assign mon_dreg      = mon_q;
  assign monitor_ready = rdy_q;
  assign jtag_overrun  = ovr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pend_q   <= 1'b0;
      jwr_q    <= 1'b0;
      jwd_q    <= '0;
      jaddr_q  <= '0;
      ptr_q    <= '0;
      last_j_q <= 1'b0;
      mon_q    <= '0;
      crd_q    <= '0;
      rdy_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (acc) begin
        pend_q <= 1'b1;
        jwr_q  <= jtag_wr;
        jwd_q  <= jtag_wdata;
      end else if (jg) begin
        pend_q <= 1'b0;
      end
      if (jg) begin
        last_j_q <= 1'b1;
        jaddr_q  <= ptr_q;
      end else if (cg) begin
        last_j_q <= 1'b0;
      end
      if (jtag_addr_load) ptr_q <= jtag_addr;
      else if (done)      ptr_q <= ptr_q + ADDR_W'(1);
      if (state_q == J_RDW) mon_q <= ram_rdata;
      if (state_q == C_RDW) crd_q <= ram_rdata;
      if (acc)       rdy_q <= 1'b0;
      else if (done) rdy_q <= 1'b1;
      if (drop)              ovr_q <= 1'b1;
      else if (jtag_ovr_clr) ovr_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_debug_ocimem_arbiter.sv
// Bench for debug_ocimem_arbiter: behavioural RAM plus write/read scoreboards.
// Scenario tasks check cycle timing inline; a negedge monitor drains the queues.
module tb_debug_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        jtag_req, jtag_wr, jtag_addr_load, jtag_ovr_clr;
  logic [31:0] jtag_wdata;
  logic [7:0]  jtag_addr;
  logic        cpu_req, cpu_wr;
  logic [7:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_waitrequest;
  logic [31:0] cpu_readdata;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] mon_dreg;
  logic        monitor_ready, jtag_overrun;

  int total = 0;
  int bad   = 0;

  logic [39:0] wq[$];
  logic [31:0] rq[$];
  logic [39:0] we_exp;
  logic [31:0] re_exp;
  logic [31:0] mem [0:255];

  debug_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .jtag_req(jtag_req), .jtag_wr(jtag_wr),
    .jtag_wdata(jtag_wdata),
    .jtag_addr_load(jtag_addr_load),
    .jtag_addr(jtag_addr),
    .jtag_ovr_clr(jtag_ovr_clr),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_waitrequest(cpu_waitrequest),
    .cpu_readdata(cpu_readdata),
    .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .mon_dreg(mon_dreg),
    .monitor_ready(monitor_ready),
    .jtag_overrun(jtag_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  always @(negedge clk) begin
    if (!reset && ram_we) begin
      total++;
      if (wq.size() == 0) begin
        bad++;
        $display("FAIL ram_wr unexpected: got addr=%h data=%h, required none",
                 ram_addr, ram_wdata);
      end else begin
        we_exp = wq.pop_front();
        if ({ram_addr, ram_wdata} !== we_exp) begin
          bad++;
          $display("FAIL ram_wr: got %h/%h, required %h/%h",
                   ram_addr, ram_wdata, we_exp[39:32], we_exp[31:0]);
        end
      end
    end
    if (!reset && cpu_req && !cpu_waitrequest && !cpu_wr) begin
      total++;
      if (rq.size() == 0) begin
        bad++;
        $display("FAIL cpu_rd unexpected: got %h", cpu_readdata);
      end else begin
        re_exp = rq.pop_front();
        if (cpu_readdata !== re_exp) begin
          bad++;
          $display("FAIL cpu_rd: got %h, required %h",
                   cpu_readdata, re_exp);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic jpulse(input logic wr, input logic [31:0] d);
    jtag_req = 1'b1;
    jtag_wr = wr;
    jtag_wdata = d;
    tick();
    jtag_req = 1'b0;
  endtask

  task automatic pload(input logic [7:0] a);
    jtag_addr_load = 1'b1;
    jtag_addr = a;
    tick();
    jtag_addr_load = 1'b0;
  endtask

  task automatic drained(input string nm);
    total++;
    if (wq.size() != 0 || rq.size() != 0) begin
      bad++;
      $display("FAIL %s: got wq=%0d rq=%0d pending, required 0/0",
               nm, wq.size(), rq.size());
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cpu_req = 1'b1;
    ticks(2);
    @(negedge clk);
    total++;
    if ({ram_we, cpu_waitrequest, monitor_ready, jtag_overrun} !== 4'b0) begin
      bad++;
      $display("FAIL rst_flags: got we/wait/rdy/ovr=%b, required 0000",
               {ram_we, cpu_waitrequest, monitor_ready, jtag_overrun});
    end
    total++;
    if (mon_dreg !== 32'h0 || cpu_readdata !== 32'h0) begin
      bad++;
      $display("FAIL rst_data: got mon=%h crd=%h, required 0/0",
               mon_dreg, cpu_readdata);
    end
    tick();
    cpu_req = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_jtag_write;
    pload(8'h10);
    wq.push_back({8'h10, 32'hDEADBEEF});
    jpulse(1'b1, 32'hDEADBEEF);
    @(negedge clk);
    total++;
    if (ram_we !== 1'b0 || monitor_ready !== 1'b0) begin
      bad++;
      $display("FAIL jwr_lat1: got we=%b rdy=%b, required 0/0",
               ram_we, monitor_ready);
    end
    tick();
    @(negedge clk);
    total++;
    if (ram_we !== 1'b1 || ram_addr !== 8'h10) begin
      bad++;
      $display("FAIL jwr_lat2: got we=%b addr=%h, required 1/10",
               ram_we, ram_addr);
    end
    tick();
    @(negedge clk);
    total++;
    if (monitor_ready !== 1'b1) begin
      bad++;
      $display("FAIL jwr_rdy: got %b, required 1", monitor_ready);
    end
    tick();
    wq.push_back({8'h11, 32'hCAFEF00D});
    jpulse(1'b1, 32'hCAFEF00D);
    ticks(4);
    drained("jwr_drain");
  endtask

  task automatic test_jtag_read;
    mem[8'hFF] = 32'h12345678;
    pload(8'hFF);
    jpulse(1'b0, 32'h0);
    tick();
    tick();
    @(negedge clk);
    total++;
    if (ram_we !== 1'b0 || mon_dreg === 32'h12345678) begin
      bad++;
      $display("FAIL jrd_lat2: got we=%b mon=%h, required 0/old",
               ram_we, mon_dreg);
    end
    tick();
    @(negedge clk);
    total++;
    if (mon_dreg !== 32'h12345678 || monitor_ready !== 1'b1) begin
      bad++;
      $display("FAIL jrd_data: got mon=%h rdy=%b, required 12345678/1",
               mon_dreg, monitor_ready);
    end
    tick();
    wq.push_back({8'h00, 32'h0BADF00D});
    jpulse(1'b1, 32'h0BADF00D);
    ticks(4);
    drained("jrd_wrap");
  endtask

  task automatic test_cpu_read;
    mem[8'h20] = 32'hA5A5A5A5;
    rq.push_back(32'hA5A5A5A5);
    cpu_req = 1'b1;
    cpu_wr = 1'b0;
    cpu_addr = 8'h20;
    tick();
    @(negedge clk);
    total++;
    if (cpu_waitrequest !== 1'b1 || ram_we !== 1'b0
        || ram_addr !== 8'h20) begin
      bad++;
      $display("FAIL crd_wait: got wait=%b we=%b addr=%h, required 1/0/20",
               cpu_waitrequest, ram_we, ram_addr);
    end
    tick();
    @(negedge clk);
    total++;
    if (cpu_waitrequest !== 1'b0 || cpu_readdata !== 32'hA5A5A5A5) begin
      bad++;
      $display("FAIL crd_done: got wait=%b data=%h, required 0/a5a5a5a5",
               cpu_waitrequest, cpu_readdata);
    end
    tick();
    cpu_req = 1'b0;
    mem[8'h20] = 32'h0;
    ticks(2);
    @(negedge clk);
    total++;
    if (cpu_readdata !== 32'hA5A5A5A5) begin
      bad++;
      $display("FAIL crd_hold: got %h, required a5a5a5a5", cpu_readdata);
    end
    tick();
    drained("crd_drain");
  endtask

  task automatic test_tie;
    pload(8'h30);
    wq.push_back({8'h30, 32'hA0A0A0A0});
    wq.push_back({8'h40, 32'hC0C0C0C0});
    wq.push_back({8'h31, 32'hB0B0B0B0});
    wq.push_back({8'h41, 32'hD0D0D0D0});
    jpulse(1'b1, 32'hA0A0A0A0);
    cpu_req = 1'b1;
    cpu_wr = 1'b1;
    cpu_addr = 8'h40;
    cpu_wdata = 32'hC0C0C0C0;
    tick();
    @(negedge clk);
    total++;
    if (ram_we !== 1'b1 || ram_addr !== 8'h30 || cpu_waitrequest !== 1'b1) begin
      bad++;
      $display("FAIL tie1_jtag: got we=%b addr=%h wait=%b, required 1/30/1",
               ram_we, ram_addr, cpu_waitrequest);
    end
    tick();
    jpulse(1'b1, 32'hB0B0B0B0);
    @(negedge clk);
    total++;
    if (cpu_waitrequest !== 1'b0 || ram_addr !== 8'h40) begin
      bad++;
      $display("FAIL tie1_cpu: got wait=%b addr=%h, required 0/40",
               cpu_waitrequest, ram_addr);
    end
    tick();
    cpu_addr = 8'h41;
    cpu_wdata = 32'hD0D0D0D0;
    tick();
    @(negedge clk);
    total++;
    if (ram_we !== 1'b1 || ram_addr !== 8'h31) begin
      bad++;
      $display("FAIL tie2_jtag: got we=%b addr=%h, required 1/31",
               ram_we, ram_addr);
    end
    ticks(2);
    @(negedge clk);
    total++;
    if (cpu_waitrequest !== 1'b0) begin
      bad++;
      $display("FAIL tie2_cpu: got wait=%b, required 0", cpu_waitrequest);
    end
    tick();
    cpu_req = 1'b0;
    ticks(3);
    drained("tie_drain");
  endtask

  task automatic test_overrun;
    pload(8'h50);
    wq.push_back({8'h50, 32'h11111111});
    jpulse(1'b1, 32'h11111111);
    jpulse(1'b1, 32'h22222222);
    @(negedge clk);
    total++;
    if (jtag_overrun !== 1'b1) begin
      bad++;
      $display("FAIL ovr_set: got %b, required 1", jtag_overrun);
    end
    ticks(4);
    @(negedge clk);
    total++;
    if (jtag_overrun !== 1'b1) begin
      bad++;
      $display("FAIL ovr_sticky: got %b, required 1", jtag_overrun);
    end
    drained("ovr_one_access");
    tick();
    jtag_ovr_clr = 1'b1;
    tick();
    jtag_ovr_clr = 1'b0;
    @(negedge clk);
    total++;
    if (jtag_overrun !== 1'b0) begin
      bad++;
      $display("FAIL ovr_clr: got %b, required 0", jtag_overrun);
    end
    tick();
    wq.push_back({8'h51, 32'h33333333});
    jpulse(1'b1, 32'h33333333);
    jtag_ovr_clr = 1'b1;
    jpulse(1'b1, 32'h44444444);
    jtag_ovr_clr = 1'b0;
    @(negedge clk);
    total++;
    if (jtag_overrun !== 1'b1) begin
      bad++;
      $display("FAIL ovr_setwins: got %b, required 1", jtag_overrun);
    end
    ticks(4);
    drained("ovr_drain");
    jtag_ovr_clr = 1'b1;
    tick();
    jtag_ovr_clr = 1'b0;
  endtask

  task automatic test_load_prio;
    pload(8'h60);
    wq.push_back({8'h60, 32'h66666666});
    jpulse(1'b1, 32'h66666666);
    tick();
    jtag_addr_load = 1'b1;
    jtag_addr = 8'h80;
    tick();
    jtag_addr_load = 1'b0;
    tick();
    wq.push_back({8'h80, 32'h88888888});
    jpulse(1'b1, 32'h88888888);
    ticks(4);
    drained("load_prio");
  endtask

  task automatic test_reset_mid;
    pload(8'h70);
    cpu_req = 1'b1;
    cpu_wr = 1'b0;
    cpu_addr = 8'h20;
    tick();
    reset = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    total++;
    if (ram_we !== 1'b0 || cpu_waitrequest !== 1'b0
        || cpu_readdata !== 32'h0) begin
      bad++;
      $display("FAIL rmid_in: got we=%b wait=%b crd=%h, required 0/0/0",
               ram_we, cpu_waitrequest, cpu_readdata);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({ram_we, cpu_waitrequest, monitor_ready} !== 3'b0
        || mon_dreg !== 32'h0) begin
      bad++;
      $display("FAIL rmid_after: got we/wait/rdy=%b mon=%h, required 000/0",
               {ram_we, cpu_waitrequest, monitor_ready}, mon_dreg);
    end
    tick();
    wq.push_back({8'h00, 32'h77777777});
    jpulse(1'b1, 32'h77777777);
    ticks(4);
    drained("rmid_ptr");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    reset = 1'b1;
    jtag_req = 1'b0;
    jtag_wr = 1'b0;
    jtag_wdata = '0;
    jtag_addr_load = 1'b0;
    jtag_addr = '0;
    jtag_ovr_clr = 1'b0;
    cpu_req = 1'b0;
    cpu_wr = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    #1;
    test_reset();
    test_jtag_write();
    test_jtag_read();
    test_cpu_read();
    test_tie();
    test_overrun();
    test_load_prio();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, required finish by 100000");
    $fatal(1);
  end

endmodule
